reg_bank_16bit_4r: RTL and testbench

//   Four-entry 16-bit register bank (R0..R3) for the multi-register accumulator datapath.

---
 rtl/reg_bank_16bit_4r_pkg.sv | 12 +
 rtl/reg_16bit_en.sv | 35 +++
 rtl/reg_bank_16bit_4r.sv | 131 +++++++++++++
 tb/tb_reg_bank_16bit_4r.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_16bit_4r_pkg.sv
// rtl/reg_bank_16bit_4r_pkg.sv - shared width default and opcode constants for the register bank
package reg_bank_16bit_4r_pkg;

    localparam int WIDTH_DEF = 16;

    // Opcodes, shared with the upstream decoder
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_MOV  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;
    localparam logic [1:0] OP_SWAP = 2'd3;

endpackage

// File: rtl/reg_16bit_en.sv
// rtl/reg_16bit_en.sv - WIDTH-bit register with sync active-low reset and load enable
module reg_16bit_en #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Hold unless enabled
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // Reset has priority over any load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_bank_16bit_4r.sv
// rtl/reg_bank_16bit_4r.sv - four-entry register bank executing LOAD/MOV/CLR/SWAP over valid/ready
module reg_bank_16bit_4r
    import reg_bank_16bit_4r_pkg::*;
#(
    parameter int               WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [1:0]       rd,
    input  logic [1:0]       rs,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic             done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWAP2 = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [1:0]       rs_q, rs_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] r_q [4];
    logic             wr_we;
    logic [1:0]       wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       wr_en;
    logic             accept;

    assign op_ready = (state_q == ST_IDLE);
    assign accept   = op_valid & op_ready;

    // Next-state and single write-port selection; SWAP uses the port twice, once per state
    always_comb begin
        state_d = state_q;
        tmp_d   = tmp_q;
        rs_d    = rs_q;
        done_d  = 1'b0;
        wr_we   = 1'b0;
        wr_idx  = rd;
        wr_data = wdata;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_we  = 1'b1;
                    wr_idx = rd;
                    case (op_code)
                        OP_LOAD: begin
                            wr_data = wdata;
                            done_d  = 1'b1;
                        end
                        OP_MOV: begin
                            wr_data = r_q[rs];
                            done_d  = 1'b1;
                        end
                        OP_CLR: begin
                            wr_data = '0;
                            done_d  = 1'b1;
                        end
                        default: begin
                            wr_data = r_q[rs];
                            tmp_d   = r_q[rd];
                            rs_d    = rs;
                            state_d = ST_SWAP2;
                        end
                    endcase
                end
            end
            default: begin
                wr_we   = 1'b1;
                wr_idx  = rs_q;
                wr_data = tmp_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decode the write index into per-register load enables
    always_comb begin
        wr_en = 4'b0000;
        if (wr_we) begin
            wr_en = 4'b0001 << wr_idx;
        end
    end

    // FSM, swap scratch and completion pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmp_q   <= RESET_VAL;
            rs_q    <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmp_q   <= tmp_d;
            rs_q    <= rs_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_reg
        reg_16bit_en #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_en[i]),
            .d     (wr_data),
            .q     (r_q[i])
        );
    end

    assign r0   = r_q[0];
    assign r1   = r_q[1];
    assign r2   = r_q[2];
    assign r3   = r_q[3];
    assign done = done_q;

endmodule

// File: tb/tb_reg_bank_16bit_4r.sv
// tb/tb_reg_bank_16bit_4r.sv - scoreboard bench for the four-entry register bank
module tb_reg_bank_16bit_4r;
    import reg_bank_16bit_4r_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [15:0] wdata;
    logic [15:0] r0, r1, r2, r3;
    logic        done;

    always #5 clk = ~clk;

    reg_bank_16bit_4r dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .rd       (rd),
        .rs       (rs),
        .wdata    (wdata),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .done     (done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m [4];
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model_regs();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    // Present an op, hold it until accepted, update the model and queue the expected state
    task automatic issue(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s,
                         input logic [15:0] wd, input bit track);
        bit          rdy;
        bit          ok;
        logic [15:0] t;
        ok       = 1'b0;
        op_valid = 1'b1;
        op_code  = op;
        rd       = d;
        rs       = s;
        wdata    = wd;
        for (int i = 0; i < 20; i++) begin
            rdy = op_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        op_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual not_accepted required accepted op %0d", op);
        end else if (track) begin
            case (op)
                OP_LOAD: m[d] = wd;
                OP_MOV:  m[d] = m[s];
                OP_CLR:  m[d] = 16'h0000;
                default: begin
                    t    = m[d];
                    m[d] = m[s];
                    m[s] = t;
                end
            endcase
            exp_q.push_back(model_regs());
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual 1 required 0");
            end else begin
                chk("done_regs", {r3, r2, r1, r0}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = OP_LOAD;
        rd       = 2'd0;
        rs       = 2'd0;
        wdata    = 16'h0000;
        for (int i = 0; i < 4; i++) m[i] = 16'h0000;

        // 1 reset
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_regs", {r3, r2, r1, r0}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_ready", {63'h0, op_ready}, 64'h1);

        // 2 single LOAD
        issue(OP_LOAD, 2'd2, 2'd0, 16'hBEEF, 1'b1);
        @(posedge clk);
        #1;

        // 3 back-to-back LOADs then SWAP
        issue(OP_LOAD, 2'd0, 2'd0, 16'h1234, 1'b1);
        issue(OP_LOAD, 2'd1, 2'd0, 16'hABCD, 1'b1);
        issue(OP_SWAP, 2'd0, 2'd1, 16'h0000, 1'b1);
        chk("swap2_ready", {63'h0, op_ready}, 64'h0);
        @(posedge clk);
        #1;
        chk("swap_done_ready", {63'h0, op_ready}, 64'h1);
        chk("swap_result", {32'h0, r1, r0}, {32'h0, 16'h1234, 16'hABCD});

        // 4 MOV, CLR, MOV onto itself, SWAP onto itself
        issue(OP_LOAD, 2'd0, 2'd0, 16'h00FF, 1'b1);
        issue(OP_MOV,  2'd3, 2'd0, 16'h0000, 1'b1);
        issue(OP_CLR,  2'd3, 2'd0, 16'h0000, 1'b1);
        issue(OP_MOV,  2'd1, 2'd1, 16'h0000, 1'b1);
        issue(OP_SWAP, 2'd2, 2'd2, 16'h0000, 1'b1);
        @(posedge clk);
        #1;

        // 5 LOAD held during SWAP2 must wait for IDLE
        issue(OP_SWAP, 2'd2, 2'd3, 16'h0000, 1'b1);
        op_valid = 1'b1;
        op_code  = OP_LOAD;
        rd       = 2'd3;
        rs       = 2'd0;
        wdata    = 16'h5555;
        chk("held_ready", {63'h0, op_ready}, 64'h0);
        @(posedge clk);
        #1;
        chk("held_not_taken", {r3, r2, r1, r0}, model_regs());
        issue(OP_LOAD, 2'd3, 2'd0, 16'h5555, 1'b1);
        chk("held_load_r3", {48'h0, r3}, {48'h0, 16'h5555});

        // 6 reset during SWAP2
        issue(OP_SWAP, 2'd0, 2'd3, 16'h0000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m[i] = 16'h0000;
        chk("swap_reset_regs", {r3, r2, r1, r0}, 64'h0);
        chk("swap_reset_ready", {63'h0, op_ready}, 64'h1);
        @(negedge clk);
        chk("swap_reset_done", {63'h0, done}, 64'h0);
        @(posedge clk);
        #1;
        chk("idle_hold", {r3, r2, r1, r0}, 64'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
